// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - opcodes, widths and format enum for the RV32I immediate generator
package imm_gen_pkg;

  localparam int INSTR_W = 32;
  localparam int IMM_W   = 12;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_I    = 2'd1,
    FMT_S    = 2'd2,
    FMT_B    = 2'd3
  } imm_fmt_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational opcode-to-format decode and 12-bit immediate extraction
// IMM_EXT_OPS_EN adds OP-IMM and JALR as I-type formats.
module imm_decode
  import imm_gen_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output imm_fmt_t           fmt_o,
  output logic [IMM_W-1:0]   imm_o
);

  // funct3 and rs1 never take part in any immediate.
  logic unused_fields;
  assign unused_fields = ^instr_i[19:12];

  always_comb begin
    fmt_o = FMT_NONE;
    case (instr_i[6:0])
      OPC_LOAD:   fmt_o = FMT_I;
      OPC_STORE:  fmt_o = FMT_S;
      OPC_BRANCH: fmt_o = FMT_B;
`ifdef IMM_EXT_OPS_EN
      OPC_OPIMM,
      OPC_JALR:   fmt_o = FMT_I;
`else
      OPC_OPIMM,
      OPC_JALR:   fmt_o = FMT_NONE;
`endif
      default:    fmt_o = FMT_NONE;
    endcase
  end

  // Branch immediate is offset bits [12:1]; bit 0 is implicitly zero.
  always_comb begin
    imm_o = '0;
    case (fmt_o)
      FMT_I:   imm_o = instr_i[31:20];
      FMT_S:   imm_o = {instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm_o = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - registered RV32I immediate generator, one cycle latency with valid flag
// Optional macro IMM_EXT_OPS_EN (handled in imm_decode) enables OP-IMM/JALR decoding.
module imm_gen
  import imm_gen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] instruction,
  output logic [IMM_W-1:0]   immediate,
  output logic               out_valid
);

  imm_fmt_t         dec_fmt;
  logic [IMM_W-1:0] dec_imm;
  logic [IMM_W-1:0] imm_d, imm_q;
  logic             valid_d, valid_q;

  imm_decode u_decode (
    .instr_i (instruction),
    .fmt_o   (dec_fmt),
    .imm_o   (dec_imm)
  );

  logic unused_fmt;
  assign unused_fmt = ^dec_fmt;

  // The mux keeps an undriven instruction out of the held immediate.
  assign imm_d   = in_valid ? dec_imm : imm_q;
  assign valid_d = in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  end

  assign immediate = imm_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_imm_gen.sv
// tb/tb_imm_gen.sv - randomized and directed self-checking bench for imm_gen
module tb_imm_gen;

`ifdef IMM_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction;
  logic [11:0] immediate;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_imm;
  logic        exp_valid;

  imm_gen dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .instruction (instruction),
    .immediate   (immediate),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_imm(input logic [31:0] w);
    int unsigned u, op, off;
    u  = w;
    op = u & 32'd127;
    if (op == 3 || (EXT && (op == 19 || op == 103)))
      return 12'((u >> 20) & 32'hFFF);
    if (op == 35)
      return 12'((((u >> 25) & 32'd127) << 5) | ((u >> 7) & 32'd31));
    if (op == 99) begin
      off = (((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11)
          | (((u >> 25) & 32'd63) << 5) | (((u >> 8) & 32'd15) << 1);
      return 12'((off >> 1) & 32'hFFF);
    end
    return 12'h000;
  endfunction

  // Present one input for one clock edge, advance the model, check against it.
  task automatic drive(input logic v, input logic [31:0] w);
    in_valid    = v;
    instruction = w;
    @(posedge clk);
    exp_valid = v;
    if (v) exp_imm = ref_imm(w);
    #1;
    chk("model_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    chk("model_imm", {20'd0, immediate}, {20'd0, exp_imm});
  endtask

  logic [6:0] opc_tab [6] = '{7'b0000011, 7'b0100011, 7'b1100011,
                              7'b0010011, 7'b1100111, 7'b0110011};

  initial begin
    exp_imm     = 12'h000;
    exp_valid   = 1'b0;
    rst         = 1'b1;
    in_valid    = 1'b1;
    instruction = 32'hFFFF_FF83;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_imm", {20'd0, immediate}, 32'h0);
    chk("reset_valid", {31'd0, out_valid}, 32'h0);
    rst = 1'b0;
    #2;
    chk("post_reset_hold_imm", {20'd0, immediate}, 32'h0);
    chk("post_reset_hold_valid", {31'd0, out_valid}, 32'h0);

    drive(1'b1, 32'b1111_1111_1111_1111_1111_1111_1000_0000);
    chk("default_opc", {20'd0, immediate}, 32'h000);
    chk("default_valid", {31'd0, out_valid}, 32'h1);
    drive(1'b1, 32'b0000_1111_1111_1111_1111_1111_0110_0011);
    chk("branch", {20'd0, immediate}, 32'h07F);
    drive(1'b1, 32'b0101_0101_0101_0111_1111_1111_1000_0011);
    chk("load", {20'd0, immediate}, 32'h555);
    drive(1'b1, 32'b0101_0101_1111_1111_1111_1010_1010_0011);
    chk("store", {20'd0, immediate}, 32'h555);

    drive(1'b1, 32'hABC0_0003);
    chk("b2b_load", {20'd0, immediate}, 32'hABC);
    drive(1'b1, 32'hFE00_0FA3);
    chk("b2b_store", {20'd0, immediate}, 32'hFFF);
    drive(1'b1, 32'h8000_0063);
    chk("b2b_branch", {20'd0, immediate}, 32'h800);
    drive(1'b0, 32'hxxxx_xxxx);
    chk("drop_valid", {31'd0, out_valid}, 32'h0);
    chk("drop_hold", {20'd0, immediate}, 32'h800);
    drive(1'b0, 32'h1234_5603);
    chk("idle_hold", {20'd0, immediate}, 32'h800);

    drive(1'b1, 32'h7FF0_0013);
    chk("ext_opimm", {20'd0, immediate}, EXT ? 32'h7FF : 32'h000);
    drive(1'b1, 32'h8010_0067);
    chk("ext_jalr", {20'd0, immediate}, EXT ? 32'h801 : 32'h000);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = opc_tab[$urandom_range(0, 5)];
      drive($urandom_range(0, 3) != 0, w);
      if (i == 150) begin
        // Asynchronous reset between edges must clear outputs at once.
        #2 rst = 1'b1;
        #1;
        chk("async_rst_imm", {20'd0, immediate}, 32'h0);
        chk("async_rst_valid", {31'd0, out_valid}, 32'h0);
        exp_imm   = 12'h000;
        exp_valid = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_edge_imm", {20'd0, immediate}, 32'h0);
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
